// File: rtl/fraction_multiplier_param.sv
// fraction_multiplier_param
//   Sequential signed-fraction multiplier. Two N-bit two's-complement fractions
//   (Q0.N-1) are multiplied by add-and-shift, one iteration per clock. The result
//   is a 2N-1 bit Q0.2N-2 product: the full 2N-bit product with its redundant
//   sign bit dropped.
//
//   Optional build macro FRAC_MULT_SAT_EN:
//     - Defined: -1 x -1 saturates to 0111..1 and raises ovf.
//     - Undefined: -1 x -1 wraps to 1000..0 and ovf is always 0.
//
// Parameters
//   N        operand width in bits (N >= 2)
//
// Ports
//   clk      clock; all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   st       start request; accepted in IDLE or DONE
//   mplier   multiplier, sampled only on the accepting edge
//   mcand    multiplicand, sampled only on the accepting edge
//   product  registered result; changes only on the completion edge
//   done     result valid; held until the next accepted start
//   busy     multiply in progress
//   ovf      -1 x -1 saturation flag
module fraction_multiplier_param #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           st,
  input  logic [N-1:0]   mplier,
  input  logic [N-1:0]   mcand,
  output logic [2*N-2:0] product,
  output logic           done,
  output logic           busy,
  output logic           ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  // The accumulator carries one extra bit so that the add or subtract cannot
  // overflow before the arithmetic shift.
  logic [N:0]     a_reg, a_next;
  logic [N-1:0]   b_reg, b_next;
  logic [N-1:0]   c_reg, c_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [2*N-2:0] product_reg, product_next;
  logic           done_reg, done_next;
  logic           busy_reg, busy_next;
  logic           ovf_reg, ovf_next;

  // Datapath for one iteration.
  logic [N:0]     c_ext;
  logic [N:0]     sum;
  logic [N:0]     a_sh;
  logic [N-1:0]   b_sh;
  logic           last_iter;
  logic [2*N-2:0] low_product;

  always_comb begin
    c_ext     = {c_reg[N-1], c_reg};
    last_iter = (count_reg == CW'(N-1));
    // The sign bit of the multiplier has weight -1, so the final partial
    // product is subtracted instead of added.
    if (b_reg[0]) begin
      sum = last_iter ? (a_reg - c_ext) : (a_reg + c_ext);
    end else begin
      sum = a_reg;
    end
    a_sh        = {sum[N], sum[N:1]};
    b_sh        = {sum[0], b_reg[N-1:1]};
    // After the final shift, {a_sh, b_sh} holds the integer product. Bit 2N-1
    // of that product is the redundant sign bit; it lives in a_sh[N-1] and is
    // dropped here.
    low_product = {a_sh[N-2:0], b_sh};
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    c_next       = c_reg;
    count_next   = count_reg;
    product_next = product_reg;
    done_next    = done_reg;
    busy_next    = busy_reg;
    ovf_next     = ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (st) begin
          c_next     = mcand;
          b_next     = mplier;
          a_next     = '0;
          count_next = '0;
          done_next  = 1'b0;
          ovf_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_sh;
        b_next     = b_sh;
        count_next = count_reg + CW'(1);
        if (last_iter) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = DONE;
`ifdef FRAC_MULT_SAT_EN
          // The only product of magnitude +1.0 has 01 in its top two bits.
          // It comes from -1 x -1.
          if (!a_sh[N-1] && a_sh[N-2]) begin
            product_next = {1'b0, {(2*N-2){1'b1}}};
            ovf_next     = 1'b1;
          end else begin
            product_next = low_product;
          end
`else
          product_next = low_product;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      count_reg   <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      c_reg       <= c_next;
      count_reg   <= count_next;
      product_reg <= product_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign product = product_reg;
  assign done    = done_reg;
  assign busy    = busy_reg;
  assign ovf     = ovf_reg;

endmodule
